// File: rtl/amba_adder_regbank.sv
// amba_adder_regbank: AXI-Lite-side register bank driving a multi-cycle adder sequencer
module amba_adder_regbank #(
  parameter int DATA_W      = 32,
  parameter int ADD_LATENCY = 4
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic              i_en_amba_write,
  input  logic [DATA_W-1:0] i_data,
  input  logic [31:0]       i_addr_wc,
  input  logic [3:0]        i_strb,
  input  logic [31:0]       i_addr_rc,
  output logic [DATA_W-1:0] o_data_rc,
  output logic              o_is_busy,
  output logic              o_done
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t            r_state;
  logic [DATA_W-1:0] r_opa, r_opb, r_result, w_mask, w_status;
  logic [3:0]        r_cnt;
  logic              r_carry, r_done, r_busy;
  logic              w_wr, w_ctrl, w_start, w_clr, w_unused;
  logic [DATA_W:0]   w_sum;
  for (genvar k = 0; k < DATA_W; k++) begin : g_mask
    assign w_mask[k] = (k < 32) ? i_strb[(k/8)%4] : 1'b0;
  end
  assign w_wr      = i_en_amba_write && !r_busy;
  assign w_ctrl    = w_wr && i_addr_wc[1:0] == 2'd2 && i_strb[0];
  assign w_start   = w_ctrl && i_data[0];
  assign w_clr     = w_ctrl && i_data[1];
  // Operands cannot change while busy, so they serve directly as the snapshot.
  assign w_sum     = {1'b0, r_opa} + {1'b0, r_opb};
  assign w_status  = DATA_W'({r_carry, r_done, r_busy});
  assign w_unused  = ^{i_addr_wc[31:2], i_addr_rc[31:2]};
  assign o_data_rc = i_addr_rc[1:0] == 2'd0 ? r_opa :
                     i_addr_rc[1:0] == 2'd1 ? r_opb :
                     i_addr_rc[1:0] == 2'd2 ? w_status : r_result;
  assign o_is_busy = r_busy;
  assign o_done    = r_done;
  always_ff @(posedge ACLK or posedge ARST)
    if (ARST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      if (w_wr && i_addr_wc[1:0] == 2'd0) r_opa <= (r_opa & ~w_mask) | (i_data & w_mask);
      if (w_wr && i_addr_wc[1:0] == 2'd1) r_opb <= (r_opb & ~w_mask) | (i_data & w_mask);
      if (r_state == IDLE) begin
        if (w_start) begin
          r_state <= CALC;
          r_cnt   <= 4'(ADD_LATENCY - 1);
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
        end else if (w_clr) begin
          r_done  <= 1'b0;
          r_carry <= 1'b0;
        end
      end else if (r_cnt == 4'd0) begin
        r_state  <= IDLE;
        r_busy   <= 1'b0;
        r_result <= w_sum[DATA_W-1:0];
        r_carry  <= w_sum[DATA_W];
        r_done   <= 1'b1;
      end else
        r_cnt <= r_cnt - 1'b1;
    end
endmodule

// File: tb/tb_amba_adder_regbank.sv
// tb_amba_adder_regbank: scoreboard bench with a register-level reference model
module tb_amba_adder_regbank;
  localparam int L = 4;
  typedef struct packed {logic [31:0] res; logic [31:0] st;} exp_t;
  logic ACLK = 0, ARST = 1, en = 0, mon_own = 0, busy, done;
  logic [31:0] data = 0, waddr = 0, stim_raddr = 0, mon_raddr = 0, raddr, rdata;
  logic [3:0] strb = 0;
  exp_t q[$];
  int tests = 0, fails = 0;
  logic [31:0] m_reg[4];
  logic m_done, m_carry, m_busy;
  logic [32:0] m_pend;
  assign raddr = mon_own ? mon_raddr : stim_raddr;
  amba_adder_regbank #(.DATA_W(32), .ADD_LATENCY(L)) dut (
    .ACLK(ACLK), .ARST(ARST), .i_en_amba_write(en), .i_data(data), .i_addr_wc(waddr),
    .i_strb(strb), .i_addr_rc(raddr), .o_data_rc(rdata), .o_is_busy(busy), .o_done(done)
  );
  always #5 ACLK = ~ACLK;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = o;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k+:8] = d[8*k+:8];
    return r;
  endfunction
  function automatic logic [31:0] m_val(input logic [1:0] a);
    return a == 2'd2 ? {29'b0, m_carry, m_done, m_busy} : m_reg[a];
  endfunction
  task automatic model_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s, input bit push);
    if (m_busy) return;
    if (a < 2'd2) m_reg[a] = merge(m_reg[a], d, s);
    else if (a == 2'd2 && s[0]) begin
      if (d[0]) begin
        m_busy = 1;
        m_done = 0;
        m_pend = {1'b0, m_reg[0]} + {1'b0, m_reg[1]};
        if (push) q.push_back({m_pend[31:0], 29'b0, m_pend[32], 2'b10});
      end else if (d[1]) begin
        m_done = 0;
        m_carry = 0;
      end
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s, input bit push);
    @(negedge ACLK);
    en = 1; waddr = {30'($urandom), a}; data = d; strb = s;
    model_wr(a, d, s, push);
    @(negedge ACLK);
    en = 0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge ACLK);
      n++;
    end
    if (busy) begin
      tests++; fails++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", n);
    end
    #5;
    m_busy = 0; m_reg[3] = m_pend[31:0]; m_carry = m_pend[32]; m_done = 1;
  endtask
  task automatic rdx(input logic [1:0] a, input logic [31:0] exp, input string n);
    @(negedge ACLK);
    stim_raddr = {30'($urandom), a};
    #1 chk(n, rdata, exp);
  endtask
  initial begin : monitor
    bit prev;
    int cnt;
    exp_t e;
    logic [31:0] r, s;
    prev = 0; cnt = 0;
    forever begin
      @(negedge ACLK);
      if (ARST) begin
        prev = 0; cnt = 0;
      end else begin
        if (busy) cnt++;
        else if (prev) begin
          mon_own = 1; mon_raddr = 3;
          #1 r = rdata; mon_raddr = 2;
          #1 s = rdata; mon_own = 0;
          if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_completion: result %h with no pending add", r);
          end else begin
            e = q.pop_front();
            chk("sb_result", r, e.res);
            chk("sb_status", s, e.st);
            chk("sb_busy_len", 32'(cnt), 32'(L));
          end
          cnt = 0;
        end
        prev = busy;
      end
    end
  end
  initial begin
    logic [31:0] d;
    logic [3:0] s;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_done = 0; m_carry = 0; m_busy = 0; m_pend = 0;
    repeat (3) @(negedge ACLK);
    ARST = 0;
    for (int i = 0; i < 4; i++) rdx(2'(i), 32'h0, "reset_word");
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    wr(0, 32'h5, 4'hF, 1); wr(1, 32'h7, 4'hF, 1); wr(2, 32'h1, 4'h1, 1);
    wait_done();
    rdx(3, 32'hC, "add_5_7"); rdx(2, 32'h2, "status_5_7");
    chk("o_done_5_7", {31'b0, done}, 32'h1);
    wr(0, 32'hFFFF_FFFF, 4'hF, 1); wr(1, 32'h1, 4'hF, 1); wr(2, 32'h1, 4'h1, 1);
    wait_done();
    rdx(3, 32'h0, "wrap_result"); rdx(2, 32'h6, "wrap_status");
    wr(2, 32'h2, 4'h1, 1);
    rdx(2, 32'h0, "clr_done");
    wr(0, 32'h1122_3344, 4'hF, 1);
    @(negedge ACLK);
    en = 1; waddr = 0; data = 32'hAABB_CCDD; strb = 4'b0101; stim_raddr = 0;
    #1 chk("read_during_write", rdata, 32'h1122_3344);
    model_wr(0, 32'hAABB_CCDD, 4'b0101, 1);
    @(negedge ACLK);
    en = 0;
    rdx(0, 32'h11BB_33DD, "strobe_0101");
    wr(3, 32'hDEAD_BEEF, 4'hF, 1);
    rdx(3, 32'h0, "result_readonly");
    wr(1, 32'h22, 4'hF, 1); wr(2, 32'h1, 4'h1, 1); wr(1, 32'h100, 4'hF, 1);
    wait_done();
    rdx(1, 32'h22, "busy_write_ignored"); rdx(3, 32'h11BB_33FF, "busy_old_opb_sum");
    repeat (20) begin
      d = $urandom; s = 4'($urandom);
      wr(2'($urandom_range(0, 1)), d, s, 1);
      wr(0, $urandom, 4'hF, 1); wr(1, $urandom, 4'hF, 1);
      if ($urandom_range(0, 1) == 1) wr(3, $urandom, 4'hF, 1);
      wr(2, 32'h1 | ($urandom & 32'h2), 4'h1, 1);
      if ($urandom_range(0, 1) == 1) wr(2'($urandom_range(0, 3)), $urandom, 4'($urandom), 1);
      chk("rand_busy", {31'b0, busy}, {31'b0, m_busy});
      wait_done();
      for (int i = 0; i < 4; i++) rdx(2'(i), m_val(2'(i)), "rand_read");
    end
    wr(2, 32'h1, 4'h1, 0);
    @(posedge ACLK);
    #2 ARST = 1;
    #1 chk("arst_busy", {31'b0, busy}, 32'h0);
    @(negedge ACLK); @(negedge ACLK);
    ARST = 0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_done = 0; m_carry = 0; m_busy = 0;
    rdx(3, 32'h0, "arst_result"); rdx(2, 32'h0, "arst_status");
    repeat (L + 3) @(negedge ACLK);
    chk("arst_no_late_busy", {31'b0, busy}, 32'h0);
    chk("arst_no_late_done", {31'b0, done}, 32'h0);
    chk("arst_queue_empty", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
